regread_stage: RTL and testbench
================================

// Module: regread_stage
// PURPOSE
//  Decode/register-read pipeline stage sitting directly downstream of regm (32x32 regfile, async read, posedge write).
//  Drives regm read addresses from the fetched instruction and resolves operands with EX/MEM/WB bypassing.
//  Detects load-use hazards and registers the decoded operands into a valid/ready ID/EX pipeline register.
//  Feeds the execute stage.
// PARAMETERS
//  XLEN      32  datapath width (operands, pc, immediate)
//  RBITS     5   register index width
//  RA_REG    31  link register written by JAL
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst_n        in   1      synchronous reset, active-low
//  in_valid     in   1      IF/ID presents an instruction
//  in_ready     out  1      stage accepts the instruction this cycle
//  in_instr     in   32     MIPS instruction word
//  in_pc        in   XLEN   pc of in_instr
//  rf_read1     out  RBITS  to regm read1 (= instr[25:21], rs)
//  rf_read2     out  RBITS  to regm read2 (= instr[20:16], rt)
//  rf_data1     in   XLEN   from regm data1
//  rf_data2     in   XLEN   from regm data2
//  ex_wr_en/ex_wr_reg/ex_wr_data/ex_is_load   in  1/RBITS/XLEN/1  producer in EX
//  mem_wr_en/mem_wr_reg/mem_wr_data           in  1/RBITS/XLEN    producer in MEM
//  wb_wr_en/wb_wr_reg/wb_wr_data              in  1/RBITS/XLEN    producer in WB (same values drive regm write)
//  flush        in   1      squash stage contents (branch/jump redirect)
//  out_valid    out  1      ID/EX register holds a valid instruction
//  out_ready    in   1      EX accepts this cycle
//  out_pc/out_op1/out_op2/out_imm  out  XLEN  registered pc, rs operand, rt operand, sign-extended imm16
//  out_opcode/out_funct/out_shamt  out  6/6/5 registered instr fields
//  out_dst_reg  out  RBITS  destination register; 0 = no write
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out_valid=0; all other out_* = 0. in_ready is low while rst_n=0.
//  - rf_read1/rf_read2 are combinational from in_instr; no latency.
//  - Source use:
//    - rs is used except for J(02), JAL(03), LUI(0F), and R-type funct SLL/SRL/SRA(00/02/03).
//    - rt is used for R-type(00), BEQ(04), BNE(05), SW(2B).
//  - Destination:
//    - R-type -> rd.
//    - ADDI/ADDIU/SLTI/ANDI/ORI/XORI/LUI/LW -> rt.
//    - JAL -> RA_REG.
//    - All others -> 0.
//  - Operand select per source, fixed priority:
//    1. reg==0 -> 0 (never bypassed; regm mem[0] not trusted).
//    2. ex hit: ex_wr_en && ex_wr_reg==reg -> ex_wr_data.
//    3. mem hit -> mem_wr_data.
//    4. wb hit -> wb_wr_data. Covers regm write-then-read same cycle.
//    5. Otherwise rf_data.
//  - Load-use hazard = ex_wr_en && ex_is_load && ex_wr_reg!=0 && ex_wr_reg matches a *used* source.
//  - in_ready = rst_n && !hazard && (!out_valid || out_ready).
//  - Capture when in_valid && in_ready: all out_* loaded, out_valid<=1.
//  - Bubble: if out_ready && !(in_valid && in_ready), then out_valid<=0.
//  - Hold: out_valid && !out_ready -> all out_* held unchanged. Operands are not re-bypassed while held.
//  - Hazard with out_ready=1 inserts exactly one bubble per stalled cycle. Instruction stays at input (IF/ID holds).
//  - flush=1: out_valid<=0 next edge and in_ready=0 this cycle. Overrides capture, hold and hazard. Data fields may retain stale values.
//  - Simultaneous ex/mem/wb hits on the same reg: youngest (EX) wins.
// STRUCTURE
//  - Shared package mips_pkg holds:
//    - opcode/funct localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_LUI, ...).
//    - REG_ZERO=0 and REG_RA=31.
//  - One sub-module rr_bypass_mux (reg, rf_data, 3 producer ports -> operand), instantiated twice.
//  - Decode, hazard and pipeline register stay in regread_stage.
// TESTING
//  - Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=0, all out_*=0.
//  - Plain R-type ADD $3,$1,$2:
//    - Stimulus: rf_data1=5, rf_data2=7, no producers, out_ready=1.
//    - Response: next cycle out_valid=1, out_op1=5, out_op2=7, out_dst_reg=3.
//  - Bypass priority: ADD $3,$1,$2 with ex, mem and wb all writing $1 (0xA/0xB/0xC) and wb writing $2=0x22.
//    - Response: out_op1=0xA, out_op2=0x22.
//  - $0 source: ADD $3,$0,$0 with ex_wr_reg=0, ex_wr_data=0xFF, rf_data=0x99 -> out_op1=out_op2=0.
//  - Load-use: ex_is_load=1, ex_wr_reg=4; instr ADD $5,$4,$6.
//    - Cycle 1: in_ready=0 and out_valid=0 next.
//    - Cycle 2: load moves to MEM (mem_wr_data=0x44), in_ready=1, out_op1=0x44.
//    - SW using $4 only as base also stalls. LUI $4 does not stall.
//  - Backpressure then flush:
//    - out_ready=0 for 3 cycles -> out_* stable, in_ready=0.
//    - Then flush=1 -> out_valid=0 next cycle; an instruction offered during flush is not captured.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS opcode/funct encodings, widths and the ID/EX register layout
package mips_pkg;
    localparam int XLEN  = 32;
    localparam int RBITS = 5;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [RBITS-1:0] REG_ZERO = 5'd0;
    localparam logic [RBITS-1:0] REG_RA   = 5'd31;
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [XLEN-1:0]  imm;
        logic [5:0]       opcode;
        logic [5:0]       funct;
        logic [4:0]       shamt;
        logic [RBITS-1:0] dst;
    } idex_t;
endpackage

// File: rtl/rr_bypass_mux.sv
// rr_bypass_mux: picks one source operand from EX/MEM/WB producers or the regfile, youngest first
module rr_bypass_mux
    import mips_pkg::*;
(
    input  logic [RBITS-1:0] src,
    input  logic [XLEN-1:0]  rf_data,
    input  logic             ex_en,
    input  logic [RBITS-1:0] ex_reg,
    input  logic [XLEN-1:0]  ex_data,
    input  logic             mem_en,
    input  logic [RBITS-1:0] mem_reg,
    input  logic [XLEN-1:0]  mem_data,
    input  logic             wb_en,
    input  logic [RBITS-1:0] wb_reg,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  operand
);
    // $0 is forced to zero before any bypass; the WB leg covers same-cycle regfile write
    always_comb
        operand = (src == REG_ZERO)               ? '0       :
                  (ex_en  && ex_reg  == src)      ? ex_data  :
                  (mem_en && mem_reg == src)      ? mem_data :
                  (wb_en  && wb_reg  == src)      ? wb_data  : rf_data;
endmodule

// File: rtl/regread_stage.sv
// regread_stage: MIPS decode/register-read stage with bypassing, load-use stall and ID/EX register
module regread_stage
    import mips_pkg::*;
#(
    parameter logic [RBITS-1:0] RA_REG = REG_RA
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic [RBITS-1:0] rf_read1,
    output logic [RBITS-1:0] rf_read2,
    input  logic [XLEN-1:0]  rf_data1,
    input  logic [XLEN-1:0]  rf_data2,
    input  logic             ex_wr_en,
    input  logic [RBITS-1:0] ex_wr_reg,
    input  logic [XLEN-1:0]  ex_wr_data,
    input  logic             ex_is_load,
    input  logic             mem_wr_en,
    input  logic [RBITS-1:0] mem_wr_reg,
    input  logic [XLEN-1:0]  mem_wr_data,
    input  logic             wb_wr_en,
    input  logic [RBITS-1:0] wb_wr_reg,
    input  logic [XLEN-1:0]  wb_wr_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_op1,
    output logic [XLEN-1:0]  out_op2,
    output logic [XLEN-1:0]  out_imm,
    output logic [5:0]       out_opcode,
    output logic [5:0]       out_funct,
    output logic [4:0]       out_shamt,
    output logic [RBITS-1:0] out_dst_reg
);
    logic [5:0]       opcode, funct;
    logic [RBITS-1:0] rs, rt, rd, dst;
    logic [XLEN-1:0]  op1, op2;
    logic             is_r, rs_used, rt_used, hazard, take;
    idex_t            idex_q, idex_d;
    logic             valid_q, valid_d;

    assign opcode   = in_instr[31:26];
    assign rs       = in_instr[25:21];
    assign rt       = in_instr[20:16];
    assign rd       = in_instr[15:11];
    assign funct    = in_instr[5:0];
    assign rf_read1 = rs;
    assign rf_read2 = rt;
    assign is_r     = opcode == OP_RTYPE;

    always_comb begin
        rs_used = !(opcode == OP_J || opcode == OP_JAL || opcode == OP_LUI ||
                    (is_r && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)));
        rt_used = is_r || opcode == OP_BEQ || opcode == OP_BNE || opcode == OP_SW;
        dst = is_r ? rd :
              (opcode == OP_ADDI || opcode == OP_ADDIU || opcode == OP_SLTI ||
               opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI ||
               opcode == OP_LUI || opcode == OP_LW) ? rt :
              (opcode == OP_JAL) ? RA_REG : REG_ZERO;
        hazard = ex_wr_en && ex_is_load && ex_wr_reg != REG_ZERO &&
                 ((rs_used && ex_wr_reg == rs) || (rt_used && ex_wr_reg == rt));
    end

    rr_bypass_mux u_byp1 (
        .src(rs), .rf_data(rf_data1),
        .ex_en(ex_wr_en), .ex_reg(ex_wr_reg), .ex_data(ex_wr_data),
        .mem_en(mem_wr_en), .mem_reg(mem_wr_reg), .mem_data(mem_wr_data),
        .wb_en(wb_wr_en), .wb_reg(wb_wr_reg), .wb_data(wb_wr_data),
        .operand(op1)
    );

    rr_bypass_mux u_byp2 (
        .src(rt), .rf_data(rf_data2),
        .ex_en(ex_wr_en), .ex_reg(ex_wr_reg), .ex_data(ex_wr_data),
        .mem_en(mem_wr_en), .mem_reg(mem_wr_reg), .mem_data(mem_wr_data),
        .wb_en(wb_wr_en), .wb_reg(wb_wr_reg), .wb_data(wb_wr_data),
        .operand(op2)
    );

    // flush gates in_ready so it also blocks capture
    assign in_ready = rst_n && !flush && !hazard && (!valid_q || out_ready);
    assign take     = in_valid && in_ready;

    always_comb begin
        idex_d  = take ? '{pc: in_pc, op1: op1, op2: op2,
                           imm: {{(XLEN-16){in_instr[15]}}, in_instr[15:0]},
                           opcode: opcode, funct: funct, shamt: in_instr[10:6], dst: dst}
                       : idex_q;
        valid_d = flush ? 1'b0 : take ? 1'b1 : out_ready ? 1'b0 : valid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idex_q  <= idex_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = idex_q.pc;
    assign out_op1     = idex_q.op1;
    assign out_op2     = idex_q.op2;
    assign out_imm     = idex_q.imm;
    assign out_opcode  = idex_q.opcode;
    assign out_funct   = idex_q.funct;
    assign out_shamt   = idex_q.shamt;
    assign out_dst_reg = idex_q.dst;
endmodule

// File: tb/tb_regread_stage.sv
// tb_regread_stage: directed self-checking bench for regread_stage
module tb_regread_stage;
    logic        clk = 0, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, rf_data1, rf_data2, ex_wr_data, mem_wr_data, wb_wr_data;
    logic [31:0] out_pc, out_op1, out_op2, out_imm;
    logic [4:0]  rf_read1, rf_read2, ex_wr_reg, mem_wr_reg, wb_wr_reg, out_shamt, out_dst_reg;
    logic [5:0]  out_opcode, out_funct;
    logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
    int          total = 0, fails = 0;

    regread_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rf_read1(rf_read1), .rf_read2(rf_read2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
        .mem_wr_en(mem_wr_en), .mem_wr_reg(mem_wr_reg), .mem_wr_data(mem_wr_data),
        .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg), .wb_wr_data(wb_wr_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_opcode(out_opcode), .out_funct(out_funct), .out_shamt(out_shamt), .out_dst_reg(out_dst_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic no_prod;
        ex_wr_en = 0; ex_is_load = 0; ex_wr_reg = 0; ex_wr_data = 0;
        mem_wr_en = 0; mem_wr_reg = 0; mem_wr_data = 0;
        wb_wr_en = 0; wb_wr_reg = 0; wb_wr_data = 0;
    endtask

    initial begin
        no_prod();
        rst_n = 0; in_valid = 1; in_instr = 32'h00221820; in_pc = 32'h100;
        rf_data1 = 5; rf_data2 = 7; flush = 0; out_ready = 1;
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_ready", {31'd0, in_ready}, 0);
        chk("rst_op1", out_op1, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_dst", {27'd0, out_dst_reg}, 0);

        // ADD $3,$1,$2 plain
        rst_n = 1; #1;
        chk("rd1_addr", {27'd0, rf_read1}, 1);
        chk("rd2_addr", {27'd0, rf_read2}, 2);
        chk("add_ready", {31'd0, in_ready}, 1);
        tick();
        chk("add_valid", {31'd0, out_valid}, 1);
        chk("add_op1", out_op1, 5);
        chk("add_op2", out_op2, 7);
        chk("add_dst", {27'd0, out_dst_reg}, 3);
        chk("add_pc", out_pc, 32'h100);
        chk("add_funct", {26'd0, out_funct}, 32'h20);
        chk("add_imm", out_imm, 32'h00001820);

        // bypass priority
        ex_wr_en = 1; ex_wr_reg = 1; ex_wr_data = 32'hA;
        mem_wr_en = 1; mem_wr_reg = 1; mem_wr_data = 32'hB;
        wb_wr_en = 1; wb_wr_reg = 2; wb_wr_data = 32'h22;
        tick();
        chk("byp_ex_op1", out_op1, 32'hA);
        chk("byp_wb_op2", out_op2, 32'h22);
        ex_wr_en = 0; wb_wr_reg = 1; wb_wr_data = 32'hC;
        tick();
        chk("byp_mem_op1", out_op1, 32'hB);
        chk("byp_rf_op2", out_op2, 7);
        mem_wr_en = 0;
        tick();
        chk("byp_wb_op1", out_op1, 32'hC);

        // $0 sources never bypassed
        no_prod();
        in_instr = 32'h00001820; ex_wr_en = 1; ex_wr_reg = 0; ex_wr_data = 32'hFF;
        rf_data1 = 32'h99; rf_data2 = 32'h99;
        tick();
        chk("zero_op1", out_op1, 0);
        chk("zero_op2", out_op2, 0);

        // ADDI $7,$1,-4 and JAL
        no_prod();
        in_instr = 32'h2027FFFC;
        tick();
        chk("addi_dst", {27'd0, out_dst_reg}, 7);
        chk("addi_imm", out_imm, 32'hFFFFFFFC);
        chk("addi_op1", out_op1, 32'h99);
        in_instr = 32'h0C000010;
        tick();
        chk("jal_dst", {27'd0, out_dst_reg}, 31);
        chk("jal_opcode", {26'd0, out_opcode}, 3);

        // load-use on ADD $5,$4,$6
        ex_wr_en = 1; ex_is_load = 1; ex_wr_reg = 4; ex_wr_data = 32'hEE;
        in_instr = 32'h00862820; #1;
        chk("lu_ready", {31'd0, in_ready}, 0);
        tick();
        chk("lu_bubble", {31'd0, out_valid}, 0);
        no_prod();
        mem_wr_en = 1; mem_wr_reg = 4; mem_wr_data = 32'h44; #1;
        chk("lu_ready2", {31'd0, in_ready}, 1);
        tick();
        chk("lu_valid", {31'd0, out_valid}, 1);
        chk("lu_op1", out_op1, 32'h44);
        chk("lu_dst", {27'd0, out_dst_reg}, 5);

        // SW base stalls, LUI does not
        no_prod();
        ex_wr_en = 1; ex_is_load = 1; ex_wr_reg = 4;
        in_instr = 32'hAC860000; #1;
        chk("sw_stall", {31'd0, in_ready}, 0);
        in_instr = 32'h3C841234; #1;
        chk("lui_nostall", {31'd0, in_ready}, 1);
        tick();
        chk("lui_dst", {27'd0, out_dst_reg}, 4);
        chk("lui_imm", out_imm, 32'h1234);

        // backpressure then flush
        no_prod();
        in_instr = 32'h00221820; in_pc = 32'h200; rf_data1 = 5; rf_data2 = 7;
        tick();
        chk("bp_cap", out_op1, 5);
        out_ready = 0; in_instr = 32'h00862820; in_pc = 32'h300; rf_data1 = 32'h55;
        mem_wr_en = 1; mem_wr_reg = 1; mem_wr_data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'd0, in_ready}, 0);
            tick();
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_op1", out_op1, 5);
            chk("bp_pc", out_pc, 32'h200);
        end
        flush = 1; in_valid = 1; #1;
        chk("fl_ready", {31'd0, in_ready}, 0);
        tick();
        chk("fl_valid", {31'd0, out_valid}, 0);
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        chk("fl_nocap", {31'd0, out_valid}, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
